// File: rtl/cd_tx_ram_nbank.sv
// N-bank TX frame buffer: the host fills and commits banks, the serializer drains
// them in commit order. Each bank carries its committed frame length.
module cd_tx_ram_nbank #(
    parameter int DW      = 8,
    parameter int DEPTH   = 256,
    parameter int N_BANKS = 4,
    parameter int AW      = $clog2(DEPTH),
    parameter int LW      = $clog2(DEPTH + 1),
    parameter int CW      = $clog2(N_BANKS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_byte,
    input  logic          switch,
    input  logic [LW-1:0] switch_len,
    output logic          switch_err,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_byte,
    output logic [LW-1:0] rd_len,
    input  logic          rd_done,
    output logic          unread,
    output logic [CW-1:0] pending,
    output logic          full
);
    localparam int IW = $clog2(N_BANKS * DEPTH);

    logic [DW-1:0] mem [0:N_BANKS*DEPTH-1];
    logic [LW-1:0] len_reg  [N_BANKS];
    logic [LW-1:0] len_next [N_BANKS];

    logic [CW-1:0] wr_sel_reg, wr_sel_next;
    logic [CW-1:0] rd_sel_reg, rd_sel_next;
    logic [CW-1:0] pending_reg, pending_next;
    logic          switch_err_reg;
    logic [DW-1:0] rd_byte_reg;

    logic          commit_ok;
    logic          release_ok;
    logic [LW-1:0] commit_len;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign full       = (pending_reg == CW'(N_BANKS - 1));
    assign unread     = (pending_reg != '0);
    assign commit_ok  = switch && !full;
    assign release_ok = rd_done && unread;
    assign commit_len = (switch_len > LW'(DEPTH)) ? LW'(DEPTH) : switch_len;

    // Pointer wrap is an explicit compare so non-power-of-two bank counts work.
    assign wr_sel_next = !commit_ok ? wr_sel_reg :
                         (wr_sel_reg == CW'(N_BANKS - 1)) ? '0 : wr_sel_reg + 1'b1;
    assign rd_sel_next = !release_ok ? rd_sel_reg :
                         (rd_sel_reg == CW'(N_BANKS - 1)) ? '0 : rd_sel_reg + 1'b1;

    always_comb begin
        pending_next = pending_reg;
        case ({commit_ok, release_ok})
            2'b10:   pending_next = pending_reg + 1'b1;
            2'b01:   pending_next = pending_reg - 1'b1;
            default: pending_next = pending_reg;
        endcase
    end

    // The write bank is never pending, so commit and release never hit the same bank.
    generate
        for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_len
            assign len_next[gi] = (commit_ok  && wr_sel_reg == CW'(gi)) ? commit_len :
                                  (release_ok && rd_sel_reg == CW'(gi)) ? '0 : len_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_sel_reg     <= '0;
            rd_sel_reg     <= '0;
            pending_reg    <= '0;
            switch_err_reg <= 1'b0;
            for (int i = 0; i < N_BANKS; i++) len_reg[i] <= '0;
        end else begin
            wr_sel_reg     <= wr_sel_next;
            rd_sel_reg     <= rd_sel_next;
            pending_reg    <= pending_next;
            switch_err_reg <= switch && full;
            for (int i = 0; i < N_BANKS; i++) len_reg[i] <= len_next[i];
        end
    end

    assign wr_idx = IW'(wr_sel_reg) * IW'(DEPTH) + IW'(wr_addr);
    assign rd_idx = IW'(rd_sel_reg) * IW'(DEPTH) + IW'(rd_addr);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_byte;
    end

    always_ff @(posedge clk) begin
        if (reset)      rd_byte_reg <= '0;
        else if (rd_en) rd_byte_reg <= mem[rd_idx];
    end

    assign rd_byte    = rd_byte_reg;
    assign switch_err = switch_err_reg;
    assign pending    = pending_reg;
    assign rd_len     = len_reg[rd_sel_reg];
endmodule

// File: tb/tb_cd_tx_ram_nbank.sv
// Directed bench: stimulus queues cycle-tagged expectations, a negedge monitor pops
// and compares them. Instance a: 4 banks x 16 words; instance b: 3 banks x 8 words.
module tb_cd_tx_ram_nbank;
    localparam int F_PEND = 0, F_UNR = 1, F_FULL = 2, F_LEN = 3, F_ERR = 4, F_RDB = 5;
    localparam int F_B = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 0, switch = 0, rd_en = 0, rd_done = 0;
    logic [3:0] wr_addr = 0, rd_addr = 0;
    logic [7:0] wr_byte = 0;
    logic [4:0] switch_len = 0;
    logic       a_err, a_unread, a_full;
    logic [7:0] a_rd_byte;
    logic [4:0] a_rd_len;
    logic [1:0] a_pending;

    logic       b_wr_en = 0, b_switch = 0, b_rd_en = 0, b_rd_done = 0;
    logic [2:0] b_wr_addr = 0, b_rd_addr = 0;
    logic [7:0] b_wr_byte = 0;
    logic [3:0] b_switch_len = 0;
    logic       b_err, b_unread, b_full;
    logic [7:0] b_rd_byte;
    logic [3:0] b_rd_len;
    logic [1:0] b_pending;

    always #5 clk = ~clk;

    cd_tx_ram_nbank #(.DW(8), .DEPTH(16), .N_BANKS(4)) dut_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_byte(wr_byte),
        .switch(switch), .switch_len(switch_len), .switch_err(a_err), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_byte(a_rd_byte), .rd_len(a_rd_len), .rd_done(rd_done),
        .unread(a_unread), .pending(a_pending), .full(a_full));

    cd_tx_ram_nbank #(.DW(8), .DEPTH(8), .N_BANKS(3)) dut_b (
        .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_byte(b_wr_byte),
        .switch(b_switch), .switch_len(b_switch_len), .switch_err(b_err), .rd_en(b_rd_en),
        .rd_addr(b_rd_addr), .rd_byte(b_rd_byte), .rd_len(b_rd_len), .rd_done(b_rd_done),
        .unread(b_unread), .pending(b_pending), .full(b_full));

    typedef struct {
        int    cyc;
        int    fld;
        int    val;
        string nm;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc++;

    function automatic int sample(input int fld);
        case (fld)
            F_PEND:       return int'(a_pending);
            F_UNR:        return int'(a_unread);
            F_FULL:       return int'(a_full);
            F_LEN:        return int'(a_rd_len);
            F_ERR:        return int'(a_err);
            F_RDB:        return int'(a_rd_byte);
            F_B + F_PEND: return int'(b_pending);
            F_B + F_UNR:  return int'(b_unread);
            F_B + F_FULL: return int'(b_full);
            F_B + F_LEN:  return int'(b_rd_len);
            F_B + F_ERR:  return int'(b_err);
            default:      return -1;
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            int   got;
            e   = q.pop_front();
            got = sample(e.fld);
            checks++;
            if (e.cyc != cyc || got != e.val) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.nm, got, e.val, cyc);
            end else begin
                $display("ok   %s: %0d (cycle %0d)", e.nm, got, cyc);
            end
        end
    end

    // Expectation for the state right after the next clock edge.
    task automatic ex(input int fld, input int val, input string nm);
        exp_t e;
        e.cyc = cyc + 1;
        e.fld = fld;
        e.val = val;
        e.nm  = nm;
        q.push_back(e);
    endtask

    task automatic st(input int base, input string tag, input int pend, input int unr,
                      input int ful, input int len, input int err);
        ex(base + F_PEND, pend, {tag, ".pending"});
        ex(base + F_UNR,  unr,  {tag, ".unread"});
        ex(base + F_FULL, ful,  {tag, ".full"});
        ex(base + F_LEN,  len,  {tag, ".rd_len"});
        ex(base + F_ERR,  err,  {tag, ".switch_err"});
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        wr_en = 0; switch = 0; rd_en = 0; rd_done = 0;
        b_switch = 0; b_rd_done = 0;
    endtask

    initial begin
        // reset state
        st(0, "a_reset", 0, 0, 0, 0, 0);
        ex(F_RDB, 0, "a_reset.rd_byte");
        st(F_B, "b_reset", 0, 0, 0, 0, 0);
        cycle();
        reset = 0;

        // fill one frame, commit, read back with 1-cycle latency
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; wr_addr = 4'(i); wr_byte = 8'(8'h11 + i);
            cycle();
        end
        switch = 1; switch_len = 5'd4;
        st(0, "t1_commit", 1, 1, 0, 4, 0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            rd_en = 1; rd_addr = 4'(i);
            ex(F_RDB, 8'h11 + i, "t1_rd_byte");
            cycle();
        end
        rd_done = 1;
        st(0, "t1_release", 0, 0, 0, 0, 0);
        cycle();

        // release with nothing pending is ignored
        rd_done = 1;
        st(0, "t5_idle_release", 0, 0, 0, 0, 0);
        cycle();
        // write in the commit cycle lands in the committed bank
        wr_en = 1; wr_addr = 4'd2; wr_byte = 8'hA5; switch = 1; switch_len = 5'd3;
        st(0, "t5_commit", 1, 1, 0, 3, 0);
        cycle();
        wr_en = 1; wr_addr = 4'd2; wr_byte = 8'h5A;
        cycle();
        rd_en = 1; rd_addr = 4'd2;
        ex(F_RDB, 8'hA5, "t5_same_cycle_write");
        cycle();
        rd_done = 1;
        st(0, "t5_release", 0, 0, 0, 0, 0);
        cycle();

        // three commits fill the buffer, the fourth is refused
        wr_en = 1; wr_addr = 0; wr_byte = 8'h21; switch = 1; switch_len = 5'd5;
        st(0, "t2_commit5", 1, 1, 0, 5, 0);
        cycle();
        wr_en = 1; wr_addr = 0; wr_byte = 8'h22; switch = 1; switch_len = 5'd6;
        st(0, "t2_commit6", 2, 1, 0, 5, 0);
        cycle();
        wr_en = 1; wr_addr = 0; wr_byte = 8'h23; switch = 1; switch_len = 5'd7;
        st(0, "t2_commit7", 3, 1, 1, 5, 0);
        cycle();
        switch = 1; switch_len = 5'd9;
        st(0, "t2_refused", 3, 1, 1, 5, 1);
        cycle();
        st(0, "t2_err_clears", 3, 1, 1, 5, 0);
        cycle();

        // full: a same-cycle release does not make room for the switch
        switch = 1; switch_len = 5'd9; rd_done = 1;
        st(0, "t4_full_sw_rel", 2, 1, 0, 6, 1);
        cycle();
        rd_en = 1; rd_addr = 0;
        ex(F_RDB, 8'h22, "t3_bank_order_rd");
        st(0, "t4_err_clears", 2, 1, 0, 6, 0);
        cycle();
        rd_done = 1;
        st(0, "t3_release6", 1, 1, 0, 7, 0);
        cycle();
        rd_en = 1; rd_addr = 0;
        ex(F_RDB, 8'h23, "t3_wrap_rd");
        cycle();
        // pending=1: commit and release together, commit length saturates
        wr_en = 1; wr_addr = 0; wr_byte = 8'h24; switch = 1; switch_len = 5'd20; rd_done = 1;
        st(0, "t4_sw_rel_sat", 1, 1, 0, 16, 0);
        cycle();
        rd_en = 1; rd_addr = 0;
        ex(F_RDB, 8'h24, "t4_commit_bank_rd");
        cycle();
        rd_done = 1;
        st(0, "t4_release", 0, 0, 0, 0, 0);
        cycle();

        // reset with two frames pending and a write in flight
        wr_en = 1; wr_addr = 0; wr_byte = 8'h31; switch = 1; switch_len = 5'd2;
        st(0, "t6_commit2", 1, 1, 0, 2, 0);
        cycle();
        switch = 1; switch_len = 5'd3;
        st(0, "t6_commit3", 2, 1, 0, 2, 0);
        cycle();
        rd_en = 1; rd_addr = 0;
        ex(F_RDB, 8'h31, "t6_rd_before_reset");
        cycle();
        reset = 1; wr_en = 1; wr_addr = 4'd1; wr_byte = 8'h77;
        st(0, "t6_reset", 0, 0, 0, 0, 0);
        ex(F_RDB, 0, "t6_reset.rd_byte");
        st(F_B, "b_reset2", 0, 0, 0, 0, 0);
        cycle();
        reset = 0;

        // three banks: full at 2 pending, pointers wrap 2->0
        b_switch = 1; b_switch_len = 4'd1;
        st(F_B, "b_commit1", 1, 1, 0, 1, 0);
        cycle();
        b_switch = 1; b_switch_len = 4'd2;
        st(F_B, "b_commit2", 2, 1, 1, 1, 0);
        cycle();
        b_switch = 1; b_switch_len = 4'd3;
        st(F_B, "b_refused", 2, 1, 1, 1, 1);
        cycle();
        b_rd_done = 1;
        st(F_B, "b_release1", 1, 1, 0, 2, 0);
        cycle();
        b_switch = 1; b_switch_len = 4'd3;
        st(F_B, "b_commit3", 2, 1, 1, 2, 0);
        cycle();
        b_rd_done = 1;
        st(F_B, "b_release2", 1, 1, 0, 3, 0);
        cycle();
        b_rd_done = 1;
        st(F_B, "b_release3", 0, 0, 0, 0, 0);
        cycle();
        b_switch = 1; b_switch_len = 4'd9;
        st(F_B, "b_wrap_commit_sat", 1, 1, 0, 8, 0);
        cycle();
        b_switch = 1; b_switch_len = 4'd2;
        st(F_B, "b_commit_after_wrap", 2, 1, 1, 8, 0);
        cycle();
        b_rd_done = 1;
        st(F_B, "b_release_after_wrap", 1, 1, 0, 2, 0);
        cycle();

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked expectations, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
